// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file: selects the writeback value,
// commits it on the clock edge and serves two combinational read ports with write-through.
module wb_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            mem_control_wb,
    input  logic [DATA_WIDTH-1:0] read_data,
    input  logic [DATA_WIDTH-1:0] mem_ALU_result,
    input  logic [ADDR_WIDTH-1:0] mem_write_reg,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    output logic                  wb_reg_write,
    output logic [ADDR_WIDTH-1:0] wb_write_reg,
    output logic [DATA_WIDTH-1:0] wb_write_data
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
    logic                  reg_write_s;
    logic [DATA_WIDTH-1:0] write_data_s;
    logic [DATA_WIDTH-1:0] read_data1_s;
    logic [DATA_WIDTH-1:0] read_data2_s;

    // Writeback mux and effective write enable; index 0 and reset suppress the write.
    always_comb begin
        write_data_s = '0;
        reg_write_s  = 1'b0;
        if (mem_control_wb[0]) begin
            write_data_s = read_data;
        end else begin
            write_data_s = mem_ALU_result;
        end
        if (mem_control_wb[1] && (mem_write_reg != '0) && !reset) begin
            reg_write_s = 1'b1;
        end else begin
            reg_write_s = 1'b0;
        end
    end

    // Read port 1 with write-through bypass of the value being committed this cycle.
    always_comb begin
        read_data1_s = '0;
        if (reset || (read_reg1 == '0)) begin
            read_data1_s = '0;
        end else if (reg_write_s && (read_reg1 == mem_write_reg)) begin
            read_data1_s = write_data_s;
        end else begin
            read_data1_s = regs_r[read_reg1];
        end
    end

    // Read port 2, bypassed independently of port 1.
    always_comb begin
        read_data2_s = '0;
        if (reset || (read_reg2 == '0)) begin
            read_data2_s = '0;
        end else if (reg_write_s && (read_reg2 == mem_write_reg)) begin
            read_data2_s = write_data_s;
        end else begin
            read_data2_s = regs_r[read_reg2];
        end
    end

    // Register storage: reset clears everything and drops any coincident write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (reg_write_s) begin
            regs_r[mem_write_reg] <= write_data_s;
        end
    end

    assign read_data1    = read_data1_s;
    assign read_data2    = read_data2_s;
    assign wb_reg_write  = reg_write_s;
    assign wb_write_reg  = mem_write_reg;
    assign wb_write_data = write_data_s;

endmodule
